ad80305_rx_dc_corr: RTL and testbench
=====================================

AD80305_RX_DC_CORR -- requirements
Module: ad80305_rx_dc_corr

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 10, log2 of the number of valid samples per DC-estimate block (legal range 4..16).
REQ-002 SHALL have port i_fpga_clk_125p, input, 1, the single 125 MHz clock; all logic is on its rising edge.
REQ-003 SHALL have port i_fpga_rst_125p, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_iqdata_fp, input, 1, valid strobe for the received IQ sample.
REQ-005 SHALL have ports i_idata and i_qdata, input, 12 each, signed received I/Q samples.
REQ-006 SHALL have port i_dc_bypass, input, 1; 1 passes samples uncorrected.
REQ-007 SHALL have port i_dc_set_sw, input, 1; 1 selects the manual offset and 0 selects the measured offset.
REQ-008 SHALL have ports i_dc_corr_idata and i_dc_corr_qdata, input, 8 each, signed manual I/Q offsets.
REQ-009 SHALL have ports o_aver_idata and o_aver_qdata, output, 12 each, signed current DC estimate.
REQ-010 SHALL have port o_dc_upd, output, 1, one-cycle pulse on each estimate update.
REQ-011 SHALL have ports o_iqdata_fp, o_idata and o_qdata, output, 1/12/12, corrected signed stream.

Function
REQ-012 SHALL count only cycles with i_iqdata_fp=1 using an AVG_LOG2-bit sample counter that wraps from 2^AVG_LOG2-1 to 0.
REQ-013 SHALL accumulate raw i_idata and i_qdata (pre-correction, independent of i_dc_bypass) into signed accumulators 12+AVG_LOG2 bits wide; overflow SHALL be impossible.
REQ-014 SHALL use a two-state FSM: ACC (accumulating) -> DUMP on the valid sample with counter=2^AVG_LOG2-1; DUMP -> ACC unconditionally after one cycle.
REQ-015 On the ACC->DUMP edge, the block SHALL latch the sum including the terminal sample and clear the accumulators to 0.
REQ-016 A valid sample arriving in DUMP SHALL be the first sample of the next block; no sample SHALL be dropped.
REQ-017 In DUMP, the block average SHALL be the latched sum arithmetically shifted right by AVG_LOG2 (floor), and the estimate SHALL be updated with o_dc_upd=1 on the following cycle.
REQ-018 The offset SHALL be selected per sample: i_dc_set_sw=1 uses the sign-extended i_dc_corr_* values; otherwise the estimate is used.
REQ-019 Output SHALL be sat12(in - offset), clamped to [-2048, +2047]; with i_dc_bypass=1, output SHALL be the input unchanged.
REQ-020 Latency SHALL be exactly 2 cycles: stage 1 registers the input, strobe and selected offset; stage 2 registers the subtract/saturate result. o_iqdata_fp SHALL be i_iqdata_fp delayed 2 cycles.
REQ-021 Data outputs SHALL update every cycle, and are meaningful only when o_iqdata_fp=1.
REQ-022 Changes to i_dc_bypass, i_dc_set_sw and i_dc_corr_* SHALL take effect on the next sample entering stage 1 and SHALL NOT disturb accumulation.
REQ-023 Before the first block completes, the estimate SHALL be 0.

Reset
REQ-024 Asserting reset (low) SHALL asynchronously clear the FSM to ACC, and clear the counter, accumulators, estimate, pipeline, o_iqdata_fp, o_dc_upd, o_idata, o_qdata, o_aver_idata and o_aver_qdata to 0.
REQ-025 Reset mid-block SHALL discard the partial sum; after release, accumulation SHALL restart at counter 0.

Configuration
REQ-026 With DC_TRACK_IIR_EN defined, the update SHALL be est <= est + ((avg - est) >>> 2), computed at 14-bit width and saturated to 12 bits.
REQ-027 Without DC_TRACK_IIR_EN defined, the update SHALL be est <= avg.

Verification (AVG_LOG2=4 unless noted)
REQ-028 Constant I=+100/Q=-50, valid every cycle, IIR off: after 16 samples, o_dc_upd pulses once, o_aver=+100/-50, and subsequent outputs are 0/0.
REQ-029 Input -2048, i_dc_set_sw=1, i_dc_corr_idata=+5: o_idata=-2048 (saturated). Input +2047 with offset -1: o_idata=+2047.
REQ-030 Valid strobe 1-of-3 cycles with the terminal sample followed by a valid sample in DUMP: the next update occurs after exactly 16 further valid samples, and all samples are counted.
REQ-031 Block sum -17 over 16 samples: o_aver_idata=-2 (floor). With DC_TRACK_IIR_EN and constant input 400 from est=0: estimates are 100, 175, 231.
REQ-032 Reset pulse after 9 samples: all outputs are 0 within the same cycle, and the first update comes 16 valid samples after release. Toggling i_dc_bypass mid-block leaves the estimate unchanged.

Source files
------------

// File: rtl/ad80305_rx_dc_corr.sv
// AD80305 RX DC-offset estimator and corrector, 2-cycle latency.
// Define DC_TRACK_IIR_EN to smooth the estimate with a 1/4-gain IIR.
module ad80305_rx_dc_corr #(
  parameter int AVG_LOG2 = 10
) (
  input  logic               i_fpga_clk_125p,
  input  logic               i_fpga_rst_125p,
  input  logic               i_iqdata_fp,
  input  logic signed [11:0] i_idata,
  input  logic signed [11:0] i_qdata,
  input  logic               i_dc_bypass,
  input  logic               i_dc_set_sw,
  input  logic signed [7:0]  i_dc_corr_idata,
  input  logic signed [7:0]  i_dc_corr_qdata,
  output logic signed [11:0] o_aver_idata,
  output logic signed [11:0] o_aver_qdata,
  output logic               o_dc_upd,
  output logic               o_iqdata_fp,
  output logic signed [11:0] o_idata,
  output logic signed [11:0] o_qdata
);

  localparam int AW = 12 + AVG_LOG2;

  typedef enum logic {
    ACC  = 1'b0,
    DUMP = 1'b1
  } state_t;

  typedef struct packed {
    logic        v;
    logic        byp;
    logic [11:0] i;
    logic [11:0] q;
    logic [11:0] oi;
    logic [11:0] oq;
  } s1_t;

  state_t state, state_nx;
  logic   last;

  logic [AVG_LOG2-1:0] cnt;
  logic signed [AW-1:0] acc_i, acc_q;
  logic signed [AW-1:0] blk_i, blk_q;
  logic signed [11:0]   avg_i, avg_q;
  logic signed [11:0]   est_i, est_q;
  logic signed [11:0]   nxt_i, nxt_q;
  logic                 upd;

  s1_t s1, s1_nx;

  function automatic logic [11:0] sat12(
    input logic signed [13:0] x
  );
    if (x > 14'sd2047) return 12'h7FF;
    if (x < -14'sd2048) return 12'h800;
    return x[11:0];
  endfunction

  always_comb begin
    state_nx = state;
    last     = 1'b0;
    unique case (state)
      ACC: begin
        if (i_iqdata_fp && cnt == '1) begin
          state_nx = DUMP;
          last     = 1'b1;
        end
      end
      DUMP: state_nx = ACC;
    endcase
  end

  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) state <= ACC;
    else                  state <= state_nx;
  end

  // Running sum including the current sample; its top 12 bits are the floor mean.
  assign blk_i = acc_i + {{AVG_LOG2{i_idata[11]}}, i_idata};
  assign blk_q = acc_q + {{AVG_LOG2{i_qdata[11]}}, i_qdata};

  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) begin
      cnt   <= '0;
      acc_i <= '0;
      acc_q <= '0;
      avg_i <= '0;
      avg_q <= '0;
    end else if (i_iqdata_fp) begin
      cnt   <= cnt + 1'b1;
      acc_i <= last ? '0 : blk_i;
      acc_q <= last ? '0 : blk_q;
      if (last) begin
        avg_i <= blk_i[AW-1:AVG_LOG2];
        avg_q <= blk_q[AW-1:AVG_LOG2];
      end
    end
  end

`ifdef DC_TRACK_IIR_EN
  logic signed [13:0] d_i, d_q;
  assign d_i   = {{2{avg_i[11]}}, avg_i} - {{2{est_i[11]}}, est_i};
  assign d_q   = {{2{avg_q[11]}}, avg_q} - {{2{est_q[11]}}, est_q};
  assign nxt_i = sat12({{2{est_i[11]}}, est_i} + (d_i >>> 2));
  assign nxt_q = sat12({{2{est_q[11]}}, est_q} + (d_q >>> 2));
`else
  assign nxt_i = avg_i;
  assign nxt_q = avg_q;
`endif

  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) begin
      est_i <= '0;
      est_q <= '0;
      upd   <= 1'b0;
    end else begin
      upd <= (state == DUMP);
      if (state == DUMP) begin
        est_i <= nxt_i;
        est_q <= nxt_q;
      end
    end
  end

  assign o_aver_idata = est_i;
  assign o_aver_qdata = est_q;
  assign o_dc_upd     = upd;

  always_comb begin
    s1_nx     = '0;
    s1_nx.v   = i_iqdata_fp;
    s1_nx.byp = i_dc_bypass;
    s1_nx.i   = i_idata;
    s1_nx.q   = i_qdata;
    s1_nx.oi  = i_dc_set_sw ? {{4{i_dc_corr_idata[7]}}, i_dc_corr_idata} : est_i;
    s1_nx.oq  = i_dc_set_sw ? {{4{i_dc_corr_qdata[7]}}, i_dc_corr_qdata} : est_q;
  end

  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) begin
      s1          <= '0;
      o_iqdata_fp <= 1'b0;
      o_idata     <= '0;
      o_qdata     <= '0;
    end else begin
      s1          <= s1_nx;
      o_iqdata_fp <= s1.v;
      o_idata     <= s1.byp ? s1.i
                   : sat12({{2{s1.i[11]}}, s1.i} - {{2{s1.oi[11]}}, s1.oi});
      o_qdata     <= s1.byp ? s1.q
                   : sat12({{2{s1.q[11]}}, s1.q} - {{2{s1.oq[11]}}, s1.oq});
    end
  end

endmodule

// File: tb/tb_ad80305_rx_dc_corr.sv
// Bench for ad80305_rx_dc_corr (AVG_LOG2=4) against a block-mean model.
// Build with DC_TRACK_IIR_EN to check the IIR estimate variant.
module tb_ad80305_rx_dc_corr;

  localparam int L = 4;
  localparam int N = 1 << L;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic fp    = 1'b0;
  logic byp   = 1'b0;
  logic sw    = 1'b0;
  logic signed [11:0] idat = '0;
  logic signed [11:0] qdat = '0;
  logic signed [7:0]  ci   = '0;
  logic signed [7:0]  cq   = '0;

  logic o_fp, o_upd;
  logic signed [11:0] o_i, o_q, o_ai, o_aq;

  int n_run  = 0;
  int n_fail = 0;

  // reference model state
  int edge_n, blk_cnt, sum_i, sum_q;
  int pend_edge, pend_i, pend_q;
  int m_est_i, m_est_q;
  int p_v, p_byp, p_i, p_q, p_oi, p_oq;
  int e_v, e_i, e_q, e_upd, e_ai, e_aq;

  always #4 clk = ~clk;

  ad80305_rx_dc_corr #(.AVG_LOG2(L)) dut (
    .i_fpga_clk_125p (clk),
    .i_fpga_rst_125p (rst_n),
    .i_iqdata_fp     (fp),
    .i_idata         (idat),
    .i_qdata         (qdat),
    .i_dc_bypass     (byp),
    .i_dc_set_sw     (sw),
    .i_dc_corr_idata (ci),
    .i_dc_corr_qdata (cq),
    .o_aver_idata    (o_ai),
    .o_aver_qdata    (o_aq),
    .o_dc_upd        (o_upd),
    .o_iqdata_fp     (o_fp),
    .o_idata         (o_i),
    .o_qdata         (o_q)
  );

  function automatic int sat12(input int x);
    if (x > 2047) return 2047;
    if (x < -2048) return -2048;
    return x;
  endfunction

  function automatic int fdiv(input int a, input int b);
    int r;
    r = a / b;
    if ((a % b != 0) && (a < 0)) r = r - 1;
    return r;
  endfunction

  function automatic int est_next(input int est, input int avg);
`ifdef DC_TRACK_IIR_EN
    return sat12(est + fdiv(avg - est, 4));
`else
    return avg + 0 * est;
`endif
  endfunction

  function automatic int rnd12();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic model_reset();
    edge_n = 0; blk_cnt = 0; sum_i = 0; sum_q = 0;
    pend_edge = -1; pend_i = 0; pend_q = 0;
    m_est_i = 0; m_est_q = 0;
    p_v = 0; p_byp = 0; p_i = 0; p_q = 0; p_oi = 0; p_oq = 0;
    e_v = 0; e_i = 0; e_q = 0; e_upd = 0; e_ai = 0; e_aq = 0;
  endtask

  // Advance the model by one rising edge using the inputs now applied.
  task automatic model_edge();
    edge_n++;
    e_v = p_v;
    e_i = p_byp ? p_i : sat12(p_i - p_oi);
    e_q = p_byp ? p_q : sat12(p_q - p_oq);
    p_v = int'(fp); p_byp = int'(byp);
    p_i = int'(idat); p_q = int'(qdat);
    p_oi = sw ? int'(ci) : m_est_i;
    p_oq = sw ? int'(cq) : m_est_q;
    e_upd = 0;
    if (edge_n == pend_edge) begin
      m_est_i = pend_i; m_est_q = pend_q;
      e_upd = 1; pend_edge = -1;
    end
    e_ai = m_est_i; e_aq = m_est_q;
    if (fp) begin
      sum_i += int'(idat); sum_q += int'(qdat);
      blk_cnt++;
      if (blk_cnt == N) begin
        pend_edge = edge_n + 1;
        pend_i = est_next(m_est_i, fdiv(sum_i, N));
        pend_q = est_next(m_est_q, fdiv(sum_q, N));
        blk_cnt = 0; sum_i = 0; sum_q = 0;
      end
    end
  endtask

  task automatic step(input logic v, input int i, input int q);
    fp = v; idat = 12'(i); qdat = 12'(q);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fp = 1'b0; byp = 1'b0; sw = 1'b0;
    idat = '0; qdat = '0; ci = '0; cq = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, rnd12(), rnd12());
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_run++;
    if ({o_fp, o_upd} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00", {o_fp, o_upd});
    end
    n_run++;
    if ({o_i, o_q} !== 24'd0) begin
      n_fail++; $display("FAIL reset_data: got %0d/%0d want 0/0", o_i, o_q);
    end
    n_run++;
    if ({o_ai, o_aq} !== 24'd0) begin
      n_fail++; $display("FAIL reset_aver: got %0d/%0d want 0/0", o_ai, o_aq);
    end
  endtask

  task automatic test_const_dc();
    int upds;
    do_reset();
    upds = 0;
    for (int k = 0; k < 24; k++) begin
      step(1'b1, 100, -50);
      if (o_upd === 1'b1) upds++;
      n_run++;
      if (o_upd !== e_upd[0] || o_ai !== e_ai[11:0] || o_aq !== e_aq[11:0]) begin
        n_fail++;
        $display("FAIL const_est k=%0d: got upd=%b %0d/%0d want upd=%0d %0d/%0d",
                 k, o_upd, o_ai, o_aq, e_upd, e_ai, e_aq);
      end
      n_run++;
      if (o_fp !== e_v[0] || o_i !== e_i[11:0] || o_q !== e_q[11:0]) begin
        n_fail++;
        $display("FAIL const_out k=%0d: got %b %0d/%0d want %0d %0d/%0d",
                 k, o_fp, o_i, o_q, e_v, e_i, e_q);
      end
    end
    n_run++;
    if (upds != 1) begin
      n_fail++; $display("FAIL const_upd_count: got %0d want 1", upds);
    end
`ifndef DC_TRACK_IIR_EN
    n_run++;
    if (o_ai !== 12'sd100 || o_aq !== -12'sd50) begin
      n_fail++; $display("FAIL const_aver: got %0d/%0d want 100/-50", o_ai, o_aq);
    end
    n_run++;
    if (o_i !== 12'sd0 || o_q !== 12'sd0) begin
      n_fail++; $display("FAIL const_corrected: got %0d/%0d want 0/0", o_i, o_q);
    end
`endif
  endtask

  task automatic test_saturation();
    do_reset();
    sw = 1'b1; ci = 8'sd5; cq = -8'sd1;
    step(1'b1, -2048, 2047);
    step(1'b0, 0, 0);
    n_run++;
    if (o_i !== -12'sd2048 || o_q !== 12'sd2047) begin
      n_fail++; $display("FAIL sat_edges: got %0d/%0d want -2048/2047", o_i, o_q);
    end
    ci = -8'sd1; cq = 8'sd5;
    step(1'b1, 2047, -2048);
    step(1'b0, 0, 0);
    n_run++;
    if (o_i !== 12'sd2047 || o_q !== -12'sd2048) begin
      n_fail++; $display("FAIL sat_edges2: got %0d/%0d want 2047/-2048", o_i, o_q);
    end
    for (int k = 0; k < 40; k++) begin
      ci = 8'($urandom); cq = 8'($urandom);
      step(1'b1, (k % 2) ? 2047 - int'($urandom_range(0, 130)) : -2048 + int'($urandom_range(0, 130)),
           rnd12());
      n_run++;
      if (o_fp !== e_v[0] || o_i !== e_i[11:0] || o_q !== e_q[11:0]) begin
        n_fail++;
        $display("FAIL sat_rand k=%0d: got %0d/%0d want %0d/%0d", k, o_i, o_q, e_i, e_q);
      end
    end
    sw = 1'b0;
  endtask

  task automatic test_sparse_strobe();
    int vc, k, upds;
    logic force_v, v;
    do_reset();
    vc = 0; k = 0; upds = 0; force_v = 1'b0;
    while (vc < 3 * N || k < 3 * N * 3 + 4) begin
      v = (vc < 3 * N) && (force_v || (k % 3 == 0));
      force_v = 1'b0;
      if (v) begin
        vc++;
        if (vc % N == 0) force_v = 1'b1;
      end
      step(v, rnd12(), rnd12());
      k++;
      if (o_upd === 1'b1) upds++;
      n_run++;
      if (o_upd !== e_upd[0] || o_ai !== e_ai[11:0] || o_aq !== e_aq[11:0]) begin
        n_fail++;
        $display("FAIL sparse_est k=%0d: got upd=%b %0d/%0d want upd=%0d %0d/%0d",
                 k, o_upd, o_ai, o_aq, e_upd, e_ai, e_aq);
      end
    end
    n_run++;
    if (upds != 3) begin
      n_fail++; $display("FAIL sparse_upd_count: got %0d want 3", upds);
    end
  endtask

  task automatic test_floor();
    int want_i[3];
    do_reset();
    for (int k = 0; k < N; k++) step(1'b1, (k == 7) ? -2 : -1, (k == 3) ? 2 : 1);
    step(1'b0, 0, 0);
    n_run++;
    if (o_upd !== 1'b1) begin
      n_fail++; $display("FAIL floor_upd: got %b want 1", o_upd);
    end
`ifdef DC_TRACK_IIR_EN
    n_run++;
    if (o_ai !== -12'sd1 || o_aq !== 12'sd0) begin
      n_fail++; $display("FAIL floor_aver: got %0d/%0d want -1/0", o_ai, o_aq);
    end
    want_i = '{100, 175, 231};
    do_reset();
`else
    n_run++;
    if (o_ai !== -12'sd2 || o_aq !== 12'sd1) begin
      n_fail++; $display("FAIL floor_aver: got %0d/%0d want -2/1", o_ai, o_aq);
    end
    want_i = '{400, 400, 400};
`endif
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < N; k++) step(1'b1, 400, 0);
      step(1'b0, 0, 0);
      n_run++;
      if (o_upd !== 1'b1 || o_ai !== 12'(want_i[b])) begin
        n_fail++;
        $display("FAIL track_blk%0d: got upd=%b %0d want 1 %0d", b, o_upd, o_ai, want_i[b]);
      end
    end
  endtask

  task automatic test_reset_midblock();
    int at;
    do_reset();
    for (int k = 0; k < 9; k++) step(1'b1, rnd12(), rnd12());
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if ({o_fp, o_upd, o_i, o_q, o_ai, o_aq} !== 50'd0) begin
      n_fail++;
      $display("FAIL midrst_zero: got fp=%b upd=%b %0d/%0d aver %0d/%0d want all 0",
               o_fp, o_upd, o_i, o_q, o_ai, o_aq);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    at = -1;
    for (int k = 1; k <= N + 3; k++) begin
      step(k <= N, 300, -300);
      if (o_upd === 1'b1 && at < 0) at = k;
    end
    n_run++;
    if (at != N + 1) begin
      n_fail++; $display("FAIL midrst_first_upd: got step %0d want %0d", at, N + 1);
    end
    n_run++;
    if (o_ai !== e_ai[11:0] || o_aq !== e_aq[11:0]) begin
      n_fail++; $display("FAIL midrst_aver: got %0d/%0d want %0d/%0d", o_ai, o_aq, e_ai, e_aq);
    end
  endtask

  task automatic test_bypass_toggle();
    do_reset();
    for (int k = 0; k < N + 6; k++) begin
      if (k == 5 || k == 9) byp = ~byp;
      step(1'b1, rnd12(), rnd12());
      n_run++;
      if (o_upd !== e_upd[0] || o_ai !== e_ai[11:0] || o_aq !== e_aq[11:0]) begin
        n_fail++;
        $display("FAIL byp_est k=%0d: got upd=%b %0d/%0d want upd=%0d %0d/%0d",
                 k, o_upd, o_ai, o_aq, e_upd, e_ai, e_aq);
      end
      n_run++;
      if (o_fp !== e_v[0] || o_i !== e_i[11:0] || o_q !== e_q[11:0]) begin
        n_fail++;
        $display("FAIL byp_out k=%0d: got %b %0d/%0d want %0d %0d/%0d",
                 k, o_fp, o_i, o_q, e_v, e_i, e_q);
      end
    end
    byp = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 800; k++) begin
      if (k % 37 == 0) begin
        byp = ($urandom_range(0, 3) == 0);
        sw  = ($urandom_range(0, 2) == 0);
        ci  = 8'($urandom); cq = 8'($urandom);
      end
      step($urandom_range(0, 3) != 0, rnd12(), rnd12());
      n_run++;
      if (o_fp !== e_v[0] || o_upd !== e_upd[0]
          || o_ai !== e_ai[11:0] || o_aq !== e_aq[11:0]) begin
        n_fail++;
        $display("FAIL rand_ctl k=%0d: got %b %b %0d/%0d want %0d %0d %0d/%0d",
                 k, o_fp, o_upd, o_ai, o_aq, e_v, e_upd, e_ai, e_aq);
      end
      if (e_v != 0) begin
        n_run++;
        if (o_i !== e_i[11:0] || o_q !== e_q[11:0]) begin
          n_fail++;
          $display("FAIL rand_data k=%0d: got %0d/%0d want %0d/%0d", k, o_i, o_q, e_i, e_q);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_const_dc();
    test_saturation();
    test_sparse_strobe();
    test_floor();
    test_reset_midblock();
    test_bypass_toggle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
